// File: rtl/adc_pkg.sv
// Shared types and sizing helpers for the serial ADC sampling controller.
package adc_pkg;

  typedef enum logic [1:0] {IDLE, CONV, SHIFT, DONE} adc_state_t;

  // Bits needed for a counter spanning 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int sclk_period(input int div);
    return 2 * div;
  endfunction

endpackage

// File: rtl/adc_sclk_gen.sv
// Enable-gated sclk divider: registered sclk plus rise/fall strobes that are
// asserted in the cycle before the corresponding sclk edge appears.
module adc_sclk_gen
  import adc_pkg::*;
#(
  parameter int SCLK_DIV = 2
)
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam int DW = cnt_width(SCLK_DIV);
  localparam logic [DW-1:0] DIV_TC = DW'(SCLK_DIV - 1);

  logic [DW-1:0] div_cnt;
  logic          tc;

  assign tc   = en && (div_cnt == DIV_TC);
  assign rise = tc && !sclk;
  assign fall = tc && sclk;

  // Dropping en parks sclk low with the divider at zero, ready for the next burst.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
    end else if (tc) begin
      div_cnt <= '0;
      sclk    <= !sclk;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

endmodule

// File: rtl/adc_sample_ctrl.sv
// Periodic ADC conversion sequencer: cs_n framing, divided sclk, MSB-first
// capture and a valid/ready sample output with overrun reporting.
//   state | meaning
//   IDLE  | waiting for a period trigger
//   CONV  | cs_n low, ADC converting, sclk idle
//   SHIFT | sclk running, one bit captured per rising edge
//   DONE  | cs_n released, sample published
module adc_sample_ctrl
  import adc_pkg::*;
#(
  parameter int SCLK_DIV      = 2,
  parameter int SAMPLE_BITS   = 12,
  parameter int CONV_CYCLES   = 4,
  parameter int SAMPLE_PERIOD = 200
)
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  output logic                   adc_cs_n,
  output logic                   adc_sclk,
  input  logic                   adc_sdo,
  output logic [SAMPLE_BITS-1:0] sample_data,
  output logic                   sample_valid,
  input  logic                   sample_ready,
  output logic                   overrun,
  output logic                   busy
);

  localparam int PW = cnt_width(SAMPLE_PERIOD);
  localparam int CW = cnt_width(CONV_CYCLES);
  localparam int BW = cnt_width(SAMPLE_BITS + 1);
  localparam logic [PW-1:0] PERIOD_LAST = PW'(SAMPLE_PERIOD - 1);
  localparam logic [CW-1:0] CONV_LOAD   = CW'(CONV_CYCLES - 1);
  localparam logic [BW-1:0] BITS_ALL    = BW'(SAMPLE_BITS);

  adc_state_t             state, state_nxt;
  logic [PW-1:0]          period_cnt;
  logic [CW-1:0]          conv_cnt;
  logic [BW-1:0]          bit_cnt;
  logic [SAMPLE_BITS-1:0] shreg;
  logic                   trigger, sclk_rise, sclk_fall, cs_n_nxt, ovr_nxt;

  assign trigger = enable && (period_cnt == '0);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst || !enable)
      period_cnt <= '0;
    else if (period_cnt == PERIOD_LAST)
      period_cnt <= '0;
    else
      period_cnt <= period_cnt + PW'(1);
  end

  adc_sclk_gen #(.SCLK_DIV(SCLK_DIV)) u_sclk_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (state == SHIFT),
    .sclk (adc_sclk),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (trigger) state_nxt = CONV;
      CONV:    if (conv_cnt == '0) state_nxt = SHIFT;
      SHIFT:   if (sclk_fall && (bit_cnt == BITS_ALL)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Overwrite of an unconsumed sample and a dropped trigger share one pulse.
  always_comb begin
    cs_n_nxt = 1'b1;
    case (state_nxt)
      CONV, SHIFT: cs_n_nxt = 1'b0;
      default:     cs_n_nxt = 1'b1;
    endcase
    ovr_nxt = (trigger && (state != IDLE)) ||
              ((state == DONE) && sample_valid && !sample_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      adc_cs_n     <= 1'b1;
      overrun      <= 1'b0;
      conv_cnt     <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      sample_data  <= '0;
      sample_valid <= 1'b0;
    end else begin
      adc_cs_n <= cs_n_nxt;
      overrun  <= ovr_nxt;
      case (state)
        IDLE: begin
          conv_cnt <= CONV_LOAD;
          bit_cnt  <= '0;
        end
        CONV: if (conv_cnt != '0) conv_cnt <= conv_cnt - CW'(1);
        SHIFT: if (sclk_rise) begin
          shreg   <= SAMPLE_BITS'({shreg, adc_sdo});
          bit_cnt <= bit_cnt + BW'(1);
        end
        default: ;
      endcase
      if (state == DONE) begin
        sample_data  <= shreg;
        sample_valid <= 1'b1;
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adc_sample_ctrl.sv
// Scoreboard bench for adc_sample_ctrl: a behavioural ADC feeds known words,
// expected samples are queued by the stimulus and checked by a monitor.
module tb_adc_sample_ctrl;

  localparam int SB = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1, enable = 1'b0, adc_sdo = 1'b0, sample_ready = 1'b1;
  logic          adc_cs_n, adc_sclk, sample_valid, overrun, busy;
  logic [SB-1:0] sample_data;

  logic          rst1 = 1'b1, en1 = 1'b0;
  logic          cs1_n, sclk1, valid1, ovr1, busy1;
  logic [SB-1:0] data1;

  adc_sample_ctrl #(.SCLK_DIV(2), .SAMPLE_BITS(SB), .CONV_CYCLES(4), .SAMPLE_PERIOD(200)) dut (
    .clk(clk), .rst(rst), .enable(enable), .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk),
    .adc_sdo(adc_sdo), .sample_data(sample_data), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .overrun(overrun), .busy(busy));

  // Short period so that a trigger lands inside a running conversion.
  adc_sample_ctrl #(.SCLK_DIV(2), .SAMPLE_BITS(SB), .CONV_CYCLES(4), .SAMPLE_PERIOD(30)) dut_short (
    .clk(clk), .rst(rst1), .enable(en1), .adc_cs_n(cs1_n), .adc_sclk(sclk1),
    .adc_sdo(1'b0), .sample_data(data1), .sample_valid(valid1),
    .sample_ready(1'b1), .overrun(ovr1), .busy(busy1));

  typedef struct packed {
    logic [SB-1:0] data;
    logic          ovr;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_mon;
  int   total = 0, bad = 0, cyc = 0;
  int   nsamp = 0, ovr_cnt = 0, nfall = 0, nfall1 = 0, ovr1_cnt = 0, ovr1_first = -1;
  int   fall_cyc = 0, low_len = 0, rise_cnt = 0, r1 = 0, r2 = 0, idx = 0;
  int   fall_hist[$];
  int   fall1[$];
  logic prev_busy = 1'b0, prev_cs = 1'b1, prev_sclk = 1'b0, prev_cs1 = 1'b1;
  logic [SB-1:0] adc_word = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, expv);
    end
  endtask

  task automatic push_exp(input logic [SB-1:0] d, input logic o);
    exp_t t;
    t.data = d;
    t.ovr  = o;
    exp_q.push_back(t);
  endtask

  // Sample monitor: a busy fall outside reset means DONE just published data.
  always @(negedge clk) begin
    if (rst) begin
      prev_busy = 1'b0;
    end else begin
      if (prev_busy && !busy) begin
        nsamp++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_sample: got 0x%0h required none", sample_data);
        end else begin
          e_mon = exp_q.pop_front();
          check("sample_data", sample_data, e_mon.data);
          check("valid_at_load", sample_valid, 1);
          check("overrun_at_load", overrun, e_mon.ovr);
        end
      end
      prev_busy = busy;
      if (overrun) ovr_cnt++;
    end
  end

  // ADC model: MSB valid at cs_n fall, next bit after each sclk falling edge.
  always @(negedge clk) begin
    if (prev_cs && !adc_cs_n) begin
      nfall++;
      fall_cyc = cyc;
      fall_hist.push_back(cyc);
      rise_cnt = 0;
      idx = 0;
    end
    if (!prev_cs && adc_cs_n) low_len = cyc - fall_cyc;
    if (!adc_cs_n && !prev_sclk && adc_sclk) begin
      rise_cnt++;
      if (rise_cnt == 1) r1 = cyc;
      if (rise_cnt == 2) r2 = cyc;
    end
    if (!adc_cs_n && prev_sclk && !adc_sclk) idx++;
    if (adc_cs_n) idx = 0;
    adc_sdo = (idx < SB) ? adc_word[SB-1-idx] : 1'b0;
    prev_cs = adc_cs_n;
    prev_sclk = adc_sclk;
  end

  always @(negedge clk) begin
    if (!rst1) begin
      if (prev_cs1 && !cs1_n) begin
        nfall1++;
        fall1.push_back(cyc);
      end
      if (ovr1) begin
        ovr1_cnt++;
        if (ovr1_first < 0) ovr1_first = cyc;
      end
      prev_cs1 = cs1_n;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  function automatic bit reached(input int kind, input int target);
    case (kind)
      0:       return nsamp >= target;
      1:       return nfall >= target;
      2:       return rise_cnt >= target;
      3:       return busy && adc_cs_n;
      default: return nfall1 >= target;
    endcase
  endfunction

  task automatic wait_for(input int kind, input int target, input int lim, input string nm);
    int i;
    i = 0;
    while (!reached(kind, target) && i < lim) begin
      step(1);
      i++;
    end
    if (!reached(kind, target)) begin
      total++;
      bad++;
      $display("FAIL %s: event not seen within %0d cycles (required target %0d)", nm, lim, target);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    enable = 1'b0;
    sample_ready = 1'b1;
    step(3);
  endtask

  int s0, n0, o0, b1;

  initial begin
    // 1: reset state, basic conversion, framing and period
    adc_word = 12'hA5C;
    step(3);
    check("rst_cs_n", adc_cs_n, 1);
    check("rst_sclk", adc_sclk, 0);
    check("rst_data", sample_data, 0);
    check("rst_valid", sample_valid, 0);
    check("rst_overrun", overrun, 0);
    check("rst_busy", busy, 0);
    push_exp(12'hA5C, 1'b0);
    rst = 1'b0;
    enable = 1'b1;
    step(1);
    check("t1_cs_low_first", adc_cs_n, 0);
    wait_for(0, 1, 120, "t1_sample");
    step(1);
    check("t1_valid_one_cycle", sample_valid, 0);
    check("t1_cs_low_len", low_len, 52);
    check("t1_sclk_rises", rise_cnt, 12);
    check("t1_sclk_period", r2 - r1, 4);
    push_exp(12'hA5C, 1'b0);
    wait_for(1, 2, 300, "t1_second_fall");
    check("t1_trigger_period", fall_hist[1] - fall_hist[0], 200);
    wait_for(0, 2, 120, "t1_second_sample");

    // 2: ready low across two conversions
    do_reset();
    sample_ready = 1'b0;
    adc_word = 12'h123;
    s0 = nsamp;
    o0 = ovr_cnt;
    push_exp(12'h123, 1'b0);
    rst = 1'b0;
    enable = 1'b1;
    wait_for(0, s0 + 1, 120, "t2_first_sample");
    adc_word = 12'h456;
    push_exp(12'h456, 1'b1);
    wait_for(0, s0 + 2, 260, "t2_second_sample");
    step(1);
    check("t2_overrun_width", overrun, 0);
    check("t2_valid_held", sample_valid, 1);
    check("t2_data_held", sample_data, 12'h456);
    sample_ready = 1'b1;
    step(1);
    check("t2_valid_cleared", sample_valid, 0);
    check("t2_overrun_count", ovr_cnt - o0, 1);

    // 3: trigger during a conversion is dropped (period 30, conversion 54)
    b1 = ovr1_cnt;
    rst1 = 1'b0;
    en1 = 1'b1;
    wait_for(4, 3, 200, "t3_three_falls");
    if (fall1.size() >= 3) begin
      check("t3_gap_a", fall1[1] - fall1[0], 60);
      check("t3_gap_b", fall1[2] - fall1[1], 60);
      check("t3_overrun_offset", ovr1_first - fall1[0], 30);
    end
    check("t3_overrun_count", ovr1_cnt - b1, 2);
    en1 = 1'b0;
    rst1 = 1'b1;

    // 4: reset in the middle of SHIFT
    do_reset();
    adc_word = 12'hFFF;
    n0 = nfall;
    rst = 1'b0;
    enable = 1'b1;
    wait_for(1, n0 + 1, 20, "t4_fall");
    wait_for(2, 5, 60, "t4_bit5");
    rst = 1'b1;
    step(1);
    check("t4_cs_n", adc_cs_n, 1);
    check("t4_sclk", adc_sclk, 0);
    check("t4_valid", sample_valid, 0);
    check("t4_busy", busy, 0);
    adc_word = 12'h3C3;
    push_exp(12'h3C3, 1'b0);
    rst = 1'b0;
    step(1);
    check("t4_restart", adc_cs_n, 0);
    wait_for(0, nsamp + 1, 120, "t4_sample");

    // 5: enable dropped during CONV
    do_reset();
    adc_word = 12'h5A5;
    s0 = nsamp;
    push_exp(12'h5A5, 1'b0);
    rst = 1'b0;
    enable = 1'b1;
    step(1);
    check("t5_conv_started", adc_cs_n, 0);
    step(1);
    enable = 1'b0;
    wait_for(0, s0 + 1, 120, "t5_sample");
    n0 = nfall;
    step(250);
    check("t5_no_more_falls", nfall - n0, 0);
    check("t5_idle", busy, 0);
    adc_word = 12'h1E7;
    push_exp(12'h1E7, 1'b0);
    enable = 1'b1;
    step(1);
    check("t5_reenable", adc_cs_n, 0);
    wait_for(0, s0 + 2, 120, "t5_second_sample");

    // 6: DONE coincides with a handshake
    do_reset();
    sample_ready = 1'b0;
    adc_word = 12'h9C6;
    s0 = nsamp;
    o0 = ovr_cnt;
    push_exp(12'h9C6, 1'b0);
    rst = 1'b0;
    enable = 1'b1;
    wait_for(0, s0 + 1, 120, "t6_first_sample");
    adc_word = 12'h0F0;
    push_exp(12'h0F0, 1'b0);
    wait_for(3, 0, 260, "t6_done");
    sample_ready = 1'b1;
    step(1);
    check("t6_valid_kept", sample_valid, 1);
    step(1);
    check("t6_valid_cleared", sample_valid, 0);
    check("t6_no_overrun", ovr_cnt - o0, 0);

    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
